// File: rtl/pcie_dma_tx_formatter.sv
// Formats DMA read requests and write bursts as 3DW MRd/MWr TLPs on a 128-bit AXI4-Stream port.
// Optional build macro DMA_WR_PRIORITY_EN: a pending write always beats a pending read.
module pcie_dma_tx_formatter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int TAG_WIDTH  = 8,
    parameter int DATA_WIDTH = 128,
    parameter int DMA_LEN    = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_dma_req,
    output logic                  o_dma_ack,
    input  logic [ADDR_WIDTH-1:0] i_dma_req_addr,
    input  logic [LEN_WIDTH-1:0]  i_dma_req_len,
    input  logic [TAG_WIDTH-1:0]  i_dma_req_tag,
    input  logic                  i_dma_data_avail,
    input  logic [ADDR_WIDTH-1:0] i_dma_wr_addr,
    output logic                  o_dma_data_rd,
    input  logic [DATA_WIDTH-1:0] i_dma_data,
    input  logic [DMA_LEN-1:0]    i_dma_len,
    output logic                  o_dma_done,
    input  logic [15:0]           i_cfg_requester_id,
    output logic [127:0]          o_tx_tdata,
    output logic [15:0]           o_tx_tkeep,
    output logic                  o_tx_tlast,
    output logic                  o_tx_tvalid,
    input  logic                  i_tx_tready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_HDR,
        WR_HDR,
        WR_DATA,
        WR_LAST,
        DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [29:0]              rd_addr_reg;
    logic [9:0]               rd_len_dw_reg;
    logic                     rd_len_four_reg;
    logic [TAG_WIDTH-1:0]     rd_tag_reg;
    logic [29:0]              wr_addr_reg;
    logic [DMA_LEN-1:0]       wr_len_reg;
    logic [DMA_LEN-1:0]       remaining_reg;
    logic [DATA_WIDTH-33:0]   carry_reg;
`ifndef DMA_WR_PRIORITY_EN
    logic                     rr_wr_reg;   // 1: a write is preferred on the next tie
`endif
    logic                     take_rd;
    logic                     take_wr;
    logic [DMA_LEN-1:0]       wr_len_eff;
    logic [31:0]              rd_dw0, rd_dw1, wr_dw0, wr_dw1;

    // Only dword-aligned addresses and dword-multiple lengths reach the TLP.
    logic unused_bits;
    assign unused_bits = ^{i_dma_req_addr[1:0], i_dma_wr_addr[1:0], i_dma_req_len[1:0]};

    assign wr_len_eff = (i_dma_len == '0) ? DMA_LEN'(1) : i_dma_len;

    assign rd_dw0 = {3'b000, 5'b00000, 14'h0, rd_len_dw_reg};
    assign rd_dw1 = {i_cfg_requester_id, rd_tag_reg, (rd_len_four_reg ? 4'h0 : 4'hF), 4'hF};
    assign wr_dw0 = {3'b010, 5'b00000, 14'h0, 10'({wr_len_reg, 2'b00})};
    assign wr_dw1 = {i_cfg_requester_id, 8'h00, 4'hF, 4'hF};

    always_comb begin
        state_next    = state_reg;
        take_rd       = 1'b0;
        take_wr       = 1'b0;
        o_dma_ack     = 1'b0;
        o_dma_data_rd = 1'b0;
        o_dma_done    = 1'b0;
        o_tx_tdata    = '0;
        o_tx_tkeep    = '0;
        o_tx_tlast    = 1'b0;
        o_tx_tvalid   = 1'b0;
        case (state_reg)
            IDLE: begin
`ifdef DMA_WR_PRIORITY_EN
                if (i_dma_data_avail)
                    take_wr = 1'b1;
                else if (i_dma_req)
                    take_rd = 1'b1;
`else
                if (i_dma_req && i_dma_data_avail) begin
                    take_wr = rr_wr_reg;
                    take_rd = !rr_wr_reg;
                end else begin
                    take_rd = i_dma_req;
                    take_wr = i_dma_data_avail;
                end
`endif
                if (take_rd)
                    state_next = RD_HDR;
                else if (take_wr)
                    state_next = WR_HDR;
            end
            RD_HDR: begin
                o_tx_tvalid = 1'b1;
                o_tx_tlast  = 1'b1;
                o_tx_tkeep  = 16'h0FFF;
                o_tx_tdata  = {32'h0, rd_addr_reg, 2'b00, rd_dw1, rd_dw0};
                if (i_tx_tready) begin
                    o_dma_ack  = 1'b1;
                    state_next = IDLE;
                end
            end
            WR_HDR: begin
                o_tx_tvalid = 1'b1;
                o_tx_tkeep  = 16'hFFFF;
                o_tx_tdata  = {i_dma_data[31:0], wr_addr_reg, 2'b00, wr_dw1, wr_dw0};
                if (i_tx_tready) begin
                    o_dma_data_rd = 1'b1;
                    state_next    = (wr_len_reg > DMA_LEN'(1)) ? WR_DATA : WR_LAST;
                end
            end
            WR_DATA: begin
                o_tx_tvalid = 1'b1;
                o_tx_tkeep  = 16'hFFFF;
                o_tx_tdata  = {i_dma_data[31:0], carry_reg};
                if (i_tx_tready) begin
                    o_dma_data_rd = 1'b1;
                    state_next    = (remaining_reg == DMA_LEN'(1)) ? WR_LAST : WR_DATA;
                end
            end
            WR_LAST: begin
                o_tx_tvalid = 1'b1;
                o_tx_tlast  = 1'b1;
                o_tx_tkeep  = 16'h0FFF;
                o_tx_tdata  = {32'h0, carry_reg};
                if (i_tx_tready)
                    state_next = DONE;
            end
            DONE: begin
                o_dma_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg       <= IDLE;
            rd_addr_reg     <= '0;
            rd_len_dw_reg   <= '0;
            rd_len_four_reg <= 1'b0;
            rd_tag_reg      <= '0;
            wr_addr_reg     <= '0;
            wr_len_reg      <= '0;
            remaining_reg   <= '0;
            carry_reg       <= '0;
`ifndef DMA_WR_PRIORITY_EN
            rr_wr_reg       <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (take_rd) begin
                rd_addr_reg     <= i_dma_req_addr[31:2];
                rd_len_dw_reg   <= i_dma_req_len[11:2];
                rd_len_four_reg <= (i_dma_req_len == LEN_WIDTH'(4));
                rd_tag_reg      <= i_dma_req_tag;
            end
            if (take_wr) begin
                wr_addr_reg <= i_dma_wr_addr[31:2];
                wr_len_reg  <= wr_len_eff;
            end
`ifndef DMA_WR_PRIORITY_EN
            if (take_rd)
                rr_wr_reg <= 1'b1;
            else if (take_wr)
                rr_wr_reg <= 1'b0;
`endif
            // Upper 96 bits of each popped word spill into the next beat.
            if (o_dma_data_rd) begin
                carry_reg     <= i_dma_data[DATA_WIDTH-1:32];
                remaining_reg <= (state_reg == WR_HDR) ? wr_len_reg - DMA_LEN'(1)
                                                       : remaining_reg - DMA_LEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_pcie_dma_tx_formatter.sv
// Bench for pcie_dma_tx_formatter: directed and randomized requests checked against a
// dword-stream reference model of the TLP layout.
`timescale 1ns/1ps
module tb_pcie_dma_tx_formatter;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_dma_req = 1'b0;
    logic         o_dma_ack;
    logic [31:0]  i_dma_req_addr = '0;
    logic [11:0]  i_dma_req_len = '0;
    logic [7:0]   i_dma_req_tag = '0;
    logic         i_dma_data_avail = 1'b0;
    logic [31:0]  i_dma_wr_addr = '0;
    logic         o_dma_data_rd;
    logic [127:0] i_dma_data = '0;
    logic [4:0]   i_dma_len = '0;
    logic         o_dma_done;
    logic [15:0]  i_cfg_requester_id = 16'h0100;
    logic [127:0] o_tx_tdata;
    logic [15:0]  o_tx_tkeep;
    logic         o_tx_tlast;
    logic         o_tx_tvalid;
    logic         i_tx_tready = 1'b1;

    always #5 i_clk = ~i_clk;

    pcie_dma_tx_formatter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_dma_req(i_dma_req), .o_dma_ack(o_dma_ack),
        .i_dma_req_addr(i_dma_req_addr), .i_dma_req_len(i_dma_req_len),
        .i_dma_req_tag(i_dma_req_tag),
        .i_dma_data_avail(i_dma_data_avail), .i_dma_wr_addr(i_dma_wr_addr),
        .o_dma_data_rd(o_dma_data_rd), .i_dma_data(i_dma_data), .i_dma_len(i_dma_len),
        .o_dma_done(o_dma_done), .i_cfg_requester_id(i_cfg_requester_id),
        .o_tx_tdata(o_tx_tdata), .o_tx_tkeep(o_tx_tkeep), .o_tx_tlast(o_tx_tlast),
        .o_tx_tvalid(o_tx_tvalid), .i_tx_tready(i_tx_tready)
    );

    int checks = 0;
    int failures = 0;
    int txn_no = 0;
    logic [127:0] wq[$];         // FWFT write-data FIFO seen by the DUT
    logic [127:0] dir_words[$];  // optional fixed payload for the next write
    bit pop_pending = 0;
    bit model_rr_wr = 0;         // 1: write wins the next tie

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tvalid"}, o_tx_tvalid, 1'b0);
        chk({tag, "_tlast"}, o_tx_tlast, 1'b0);
        chk({tag, "_tdata"}, o_tx_tdata, 128'h0);
        chk({tag, "_tkeep"}, o_tx_tkeep, 16'h0);
        chk({tag, "_ack"}, o_dma_ack, 1'b0);
        chk({tag, "_done"}, o_dma_done, 1'b0);
        chk({tag, "_data_rd"}, o_dma_data_rd, 1'b0);
    endtask

    // Serve one request chosen by the arbitration model. bp: 0 none, 1 random, 2 stall beat1 x3.
    task automatic serve(input bit drop, input int bp);
        bit do_wr, started, stall_prev, fin;
        logic [31:0] dw[$];
        logic [127:0] ed[$];
        logic [15:0] ek[$];
        logic [127:0] prev, wd;
        logic [15:0] kk;
        int n, nvalid, nbeats, idx, pops, stall_cnt;
`ifdef DMA_WR_PRIORITY_EN
        do_wr = i_dma_data_avail;
`else
        do_wr = i_dma_data_avail && (!i_dma_req || model_rr_wr);
`endif
        n = 0;
        if (do_wr) begin
            n = (i_dma_len == 5'd0) ? 1 : int'(i_dma_len);
            wq.delete();
            for (int w = 0; w < n; w++)
                wq.push_back((dir_words.size() > 0) ? dir_words.pop_front()
                                                     : {$urandom, $urandom, $urandom, $urandom});
            dir_words.delete();
            i_dma_data = wq[0];
            dw.push_back(32'h4000_0000 | (32'(n) * 4));
            dw.push_back({i_cfg_requester_id, 16'h00FF});
            dw.push_back(i_dma_wr_addr & 32'hFFFF_FFFC);
            foreach (wq[w]) begin
                wd = wq[w];
                for (int j = 0; j < 4; j++) dw.push_back(wd[32*j +: 32]);
            end
            nvalid = 3 + 4 * n;
        end else begin
            dw.push_back({20'h0, i_dma_req_len} >> 2);
            dw.push_back({i_cfg_requester_id, i_dma_req_tag,
                          (i_dma_req_len == 12'd4) ? 4'h0 : 4'hF, 4'hF});
            dw.push_back(i_dma_req_addr & 32'hFFFF_FFFC);
            nvalid = 3;
        end
        while (dw.size() % 4 != 0) dw.push_back(32'h0);
        nbeats = dw.size() / 4;
        for (int b = 0; b < nbeats; b++) begin
            ed.push_back({dw[4*b+3], dw[4*b+2], dw[4*b+1], dw[4*b]});
            kk = '0;
            for (int j = 0; j < 4; j++) if (4 * b + j < nvalid) kk[4*j +: 4] = 4'hF;
            ek.push_back(kk);
        end
        $display("txn %0d %s beats=%0d words=%0d bp=%0d", txn_no, do_wr ? "write" : "read",
                 nbeats, n, bp);
        txn_no++;

        idx = 0; started = 0; stall_prev = 0; fin = 0; pops = 0; stall_cnt = 0; prev = '0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge i_clk);
            if (pop_pending) begin
                if (wq.size() > 0) void'(wq.pop_front());
                pops++;
                pop_pending = 0;
            end
            i_dma_data = (wq.size() > 0) ? wq[0] : 128'h0;
            if (bp == 1)
                i_tx_tready = ($urandom_range(0, 2) != 0);
            else if (bp == 2 && idx == 1 && stall_cnt < 3) begin
                i_tx_tready = 1'b0;
                stall_cnt++;
            end else
                i_tx_tready = 1'b1;
            #1;
            if (!started && o_tx_tvalid) started = 1;
            if (started) begin
                chk("tvalid", o_tx_tvalid, 1'b1);
                if (stall_prev) chk("hold_tdata", o_tx_tdata, prev);
                chk("ack", o_dma_ack, !do_wr && i_tx_tready);
                chk("data_rd", o_dma_data_rd, do_wr && i_tx_tready && (idx < nbeats - 1));
                chk("done_early", o_dma_done, 1'b0);
                if (i_tx_tready) begin
                    chk($sformatf("beat%0d_tdata", idx), o_tx_tdata, ed[idx]);
                    chk($sformatf("beat%0d_tkeep", idx), o_tx_tkeep, ek[idx]);
                    chk($sformatf("beat%0d_tlast", idx), o_tx_tlast, idx == nbeats - 1);
                    idx++;
                    if (idx == nbeats) fin = 1;
                end
                pop_pending = o_dma_data_rd;
                stall_prev = !i_tx_tready;
                prev = o_tx_tdata;
                // Later changes on the served request must not leak into the TLP.
                if (drop && !fin) begin
                    if (do_wr) begin
                        i_dma_wr_addr = $urandom;
                        i_dma_len = 5'($urandom_range(1, 31));
                    end else begin
                        i_dma_req_addr = $urandom;
                        i_dma_req_len = 12'($urandom);
                        i_dma_req_tag = 8'($urandom);
                    end
                end
            end
        end
        chk("txn_completed", fin, 1'b1);
        i_tx_tready = 1'b1;
        if (do_wr) begin
            if (drop) i_dma_data_avail = 1'b0;
            @(negedge i_clk);
            #1;
            chk("done_pulse", o_dma_done, 1'b1);
            chk("done_tvalid", o_tx_tvalid, 1'b0);
            chk("pop_count", pops, n);
            @(negedge i_clk);
            #1;
            chk("done_once", o_dma_done, 1'b0);
        end else if (drop) begin
            i_dma_req = 1'b0;
        end
        model_rr_wr = !do_wr;
    endtask

    initial begin
        int w;
        // Reset state
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        chk_idle_outputs("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Directed reads
        i_dma_req_addr = 32'h1000_0040; i_dma_req_len = 12'h080; i_dma_req_tag = 8'h05;
        i_dma_req = 1'b1;
        serve(1, 0);
        i_dma_req_addr = 32'h0000_1234; i_dma_req_len = 12'd4; i_dma_req_tag = 8'hA1;
        i_dma_req = 1'b1;
        serve(1, 0);
        i_dma_req_addr = 32'hFFFF_FFFF; i_dma_req_len = 12'd0; i_dma_req_tag = 8'hFF;
        i_dma_req = 1'b1;
        serve(1, 1);

        // Directed write from the worked example, then with a 3-cycle stall on beat1
        for (int r = 0; r < 2; r++) begin
            dir_words.push_back({32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000});
            dir_words.push_back({32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444});
            i_dma_wr_addr = 32'h2000_0000; i_dma_len = 5'd2; i_dma_data_avail = 1'b1;
            serve(1, r == 0 ? 0 : 2);
        end

        // Length boundaries: 0 behaves as 1, and the maximum of 31
        i_dma_wr_addr = 32'h0000_0ABC; i_dma_len = 5'd0; i_dma_data_avail = 1'b1;
        serve(1, 0);
        i_dma_wr_addr = 32'h8765_4320; i_dma_len = 5'd31; i_dma_data_avail = 1'b1;
        serve(1, 1);

        // Randomized single-class traffic
        for (int t = 0; t < 12; t++) begin
            i_cfg_requester_id = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                i_dma_wr_addr = $urandom;
                i_dma_len = 5'($urandom_range(1, 31));
                i_dma_data_avail = 1'b1;
            end else begin
                i_dma_req_addr = $urandom;
                i_dma_req_len = 12'($urandom_range(0, 1023) * 4);
                i_dma_req_tag = 8'($urandom);
                i_dma_req = 1'b1;
            end
            serve(1, int'($urandom_range(0, 1)));
        end
        i_cfg_requester_id = 16'h0100;

        // Reset while a write is in its data phase
        i_dma_wr_addr = 32'h4000_0000; i_dma_len = 5'd4;
        wq.delete();
        for (int k = 0; k < 4; k++) wq.push_back({$urandom, $urandom, $urandom, $urandom});
        i_dma_data = wq[0];
        i_dma_data_avail = 1'b1;
        w = 0;
        do begin
            @(negedge i_clk);
            #1;
            w++;
        end while (!o_tx_tvalid && w < 10);
        chk("rst_hdr_seen", o_tx_tvalid, 1'b1);
        @(negedge i_clk);
        i_dma_data = wq[1];
        #1;
        chk("rst_in_wr_data", o_dma_data_rd, 1'b1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        #1;
        chk_idle_outputs("mid_reset");
        i_dma_data_avail = 1'b0;
        i_rst_n = 1'b1;
        wq.delete();
        pop_pending = 0;
        i_dma_data = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            #1;
            chk("post_reset_no_done", o_dma_done, 1'b0);
            chk("post_reset_no_tvalid", o_tx_tvalid, 1'b0);
        end
        model_rr_wr = 0;

        // Both classes held: arbitration order
        i_dma_req_addr = 32'h0000_5000; i_dma_req_len = 12'h010; i_dma_req_tag = 8'h33;
        i_dma_wr_addr = 32'h0000_6000; i_dma_len = 5'd3;
        i_dma_req = 1'b1;
        i_dma_data_avail = 1'b1;
        serve(0, 0);
        serve(0, 0);
        serve(0, 1);
        serve(1, 0);
        serve(1, 0);

        repeat (3) @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
